// File: rtl/iir_coef_update_sequencer_if.sv
// AXI4-Lite write channel bundle between the coefficient sequencer and the IIR filter control slave.
interface iir_coef_update_sequencer_if;
  logic [3:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/iir_coef_update_sequencer.sv
// Reprograms the IIR filter over AXI4-Lite at a stream frame boundary: pause, a0/a1/b1, resume.
// Optional macro IIR_SEQ_CLEAR_EN adds a state-clear write before resume.
module iir_coef_update_sequencer #(
  parameter int NUM_PRESETS      = 4,
  parameter int IDX_W            = 2,
  parameter int BOUNDARY_TIMEOUT = 4096
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [1:0]           cfg_sel,
  input  logic [15:0]          cfg_wdata,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [IDX_W-1:0]     req_idx,
  input  logic                 mon_tvalid,
  input  logic                 mon_tready,
  input  logic                 mon_tlast,
  iir_coef_update_sequencer_if.master m_axi,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic                 err_clr,
  output logic [IDX_W-1:0]     active_idx
);
  localparam int CNT_W = (BOUNDARY_TIMEOUT > 1) ? $clog2(BOUNDARY_TIMEOUT) : 1;

  typedef enum logic [3:0] {
    IDLE, WAIT_BND, W_PAUSE, W_A0, W_A1, W_B1,
`ifdef IIR_SEQ_CLEAR_EN
    W_CLEAR,
`endif
    W_RESUME, DONE
  } state_e;

  logic [NUM_PRESETS-1:0][2:0][15:0] tbl_q;

  state_e             state_q, succ_d;
  logic [IDX_W-1:0]   idx_q, active_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               aw_done_q, w_done_q, resp_q;
  logic               awvalid_q, wvalid_q, bready_q;
  logic [3:0]         awaddr_q, wr_addr_d;
  logic [31:0]        wdata_q, wr_data_d;
  logic               busy_q, done_q, err_q, req_ready_q;
  logic               bnd_hit, to_hit, adv_d, aw_fin, w_fin;

  assign bnd_hit = mon_tvalid & mon_tready & mon_tlast;
  assign to_hit  = (BOUNDARY_TIMEOUT != 0) && (cnt_q == CNT_W'(BOUNDARY_TIMEOUT - 1));
  assign aw_fin  = aw_done_q | (awvalid_q & m_axi.awready);
  assign w_fin   = w_done_q  | (wvalid_q  & m_axi.wready);

  // Preset table accepts writes in every state; sel 3 is a no-op.
  always_ff @(posedge aclk) begin
    if (!aresetn) tbl_q <= '0;
    else if (cfg_we && cfg_sel != 2'd3) tbl_q[cfg_idx][cfg_sel] <= cfg_wdata;
  end

  // Successor state plus the address/data it launches with; coefficients are sampled at launch.
  always_comb begin
    succ_d    = IDLE;
    adv_d     = 1'b0;
    wr_addr_d = 4'h0;
    wr_data_d = 32'h0;
    case (state_q)
      WAIT_BND: begin succ_d = W_PAUSE;  adv_d = bnd_hit | to_hit; end
      W_PAUSE:  begin succ_d = W_A0;     adv_d = resp_q; end
      W_A0:     begin succ_d = W_A1;     adv_d = resp_q; end
      W_A1:     begin succ_d = W_B1;     adv_d = resp_q; end
`ifdef IIR_SEQ_CLEAR_EN
      W_B1:     begin succ_d = W_CLEAR;  adv_d = resp_q; end
      W_CLEAR:  begin succ_d = W_RESUME; adv_d = resp_q; end
`else
      W_B1:     begin succ_d = W_RESUME; adv_d = resp_q; end
`endif
      W_RESUME: begin succ_d = DONE;     adv_d = resp_q; end
      default:  ;
    endcase
    case (succ_d)
      W_A0: begin wr_addr_d = 4'h4; wr_data_d = {{16{tbl_q[idx_q][0][15]}}, tbl_q[idx_q][0]}; end
      W_A1: begin wr_addr_d = 4'h8; wr_data_d = {{16{tbl_q[idx_q][1][15]}}, tbl_q[idx_q][1]}; end
      W_B1: begin wr_addr_d = 4'hC; wr_data_d = {{16{tbl_q[idx_q][2][15]}}, tbl_q[idx_q][2]}; end
`ifdef IIR_SEQ_CLEAR_EN
      W_CLEAR:  wr_data_d = 32'h0000_0002;
`endif
      W_RESUME: wr_data_d = 32'h0000_0001;
      default:  ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      active_q    <= '0;
      cnt_q       <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      resp_q      <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      awaddr_q    <= 4'h0;
      wdata_q     <= 32'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      // A new error wins over a simultaneous clear.
      if (bready_q && m_axi.bvalid && (m_axi.bresp != 2'b00)) err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;

      case (state_q)
        IDLE: if (req_valid) begin
          idx_q       <= req_idx;
          cnt_q       <= '0;
          busy_q      <= 1'b1;
          req_ready_q <= 1'b0;
          state_q     <= WAIT_BND;
        end
        WAIT_BND: cnt_q <= cnt_q + 1'b1;
        DONE: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          if (awvalid_q && m_axi.awready) begin awvalid_q <= 1'b0; aw_done_q <= 1'b1; end
          if (wvalid_q && m_axi.wready)   begin wvalid_q  <= 1'b0; w_done_q  <= 1'b1; end
          // Response is held one cycle in resp_q so the next write launches a cycle later.
          if (bready_q) begin
            if (m_axi.bvalid) begin bready_q <= 1'b0; resp_q <= 1'b1; end
          end else if (aw_fin && w_fin && !resp_q) begin
            bready_q <= 1'b1;
          end
        end
      endcase

      if (adv_d) begin
        resp_q    <= 1'b0;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        if (succ_d == DONE) begin
          state_q  <= DONE;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          active_q <= idx_q;
        end else begin
          state_q   <= succ_d;
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
          awaddr_q  <= wr_addr_d;
          wdata_q   <= wr_data_d;
        end
      end
    end
  end

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = 4'hF;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign req_ready     = req_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign active_idx    = active_q;
endmodule

// File: tb/tb_iir_coef_update_sequencer.sv
// Directed bench: preset table vectors through a reactive AXI4-Lite slave, plus error/busy/reset sequences.
module tb_iir_coef_update_sequencer;
`ifdef IIR_SEQ_CLEAR_EN
  localparam int NW = 6;
`else
  localparam int NW = 5;
`endif

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cfg_we;
  logic [1:0]  cfg_idx, cfg_sel;
  logic [15:0] cfg_wdata;
  logic        req_valid, req_ready;
  logic [1:0]  req_idx;
  logic        mon_tvalid, mon_tready, mon_tlast;
  logic        busy, done, err, err_clr;
  logic [1:0]  active_idx;

  iir_coef_update_sequencer_if m_axi();

  iir_coef_update_sequencer #(.NUM_PRESETS(4), .IDX_W(2), .BOUNDARY_TIMEOUT(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
    .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .m_axi(m_axi.master),
    .busy(busy), .done(done), .err(err), .err_clr(err_clr), .active_idx(active_idx)
  );

  always #5 aclk = ~aclk;

  int total, bad;
  int aw_dly, w_dly, aw_cnt, w_cnt;
  logic err_en;
  logic [3:0] err_addr;
  logic aw_got, w_got;
  logic [3:0] cur_addr;
  logic [31:0] cur_data;
  logic [35:0] log_q[$];
  int done_cnt, bready_viol;

  // Slave: readies after programmable delays, response once both halves landed.
  always @(negedge aclk) begin
    m_axi.awready = 1'b0;
    if (!m_axi.awvalid) aw_cnt = 0;
    else if (aw_cnt >= aw_dly) m_axi.awready = 1'b1;
    else aw_cnt++;
    m_axi.wready = 1'b0;
    if (!m_axi.wvalid) w_cnt = 0;
    else if (w_cnt >= w_dly) m_axi.wready = 1'b1;
    else w_cnt++;
    m_axi.bvalid = aw_got && w_got;
    m_axi.bresp  = (err_en && cur_addr == err_addr) ? 2'b10 : 2'b00;
  end

  always @(posedge aclk) begin
    if (!aresetn) begin
      aw_got = 1'b0;
      w_got  = 1'b0;
    end else begin
      if (m_axi.bready && !(aw_got && w_got)) bready_viol++;
      if (m_axi.bvalid && m_axi.bready) begin
        log_q.push_back({cur_addr, cur_data});
        aw_got = 1'b0;
        w_got  = 1'b0;
      end
      if (m_axi.awvalid && m_axi.awready) begin aw_got = 1'b1; cur_addr = m_axi.awaddr; end
      if (m_axi.wvalid && m_axi.wready)   begin w_got  = 1'b1; cur_data = m_axi.wdata;  end
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [35:0] ent(input int k);
    if (k < log_q.size()) return log_q[k];
    return '1;
  endfunction

  task automatic cfg_write(input logic [1:0] i, input logic [1:0] s, input logic [15:0] d);
    @(negedge aclk); cfg_we = 1'b1; cfg_idx = i; cfg_sel = s; cfg_wdata = d;
    @(negedge aclk); cfg_we = 1'b0;
  endtask

  task automatic set_mon(input logic v);
    mon_tvalid = v; mon_tready = v; mon_tlast = v;
  endtask

  // Issues a request; tl>0 drives a tlast handshake in cycle tl after it. fk = cycle of first awvalid.
  task automatic run_req(input logic [1:0] idx, input int tl, output int fk);
    fk = -1;
    @(negedge aclk); req_valid = 1'b1; req_idx = idx;
    for (int k = 1; k <= 40 && fk < 0; k++) begin
      @(negedge aclk);
      req_valid = 1'b0;
      if (k == 1) begin
        chk("busy_after_req", busy, 1);
        chk("req_ready_busy", req_ready, 0);
      end
      if (m_axi.awvalid) fk = k;
      set_mon(k == tl);
    end
    set_mon(1'b0);
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge aclk);
      if (req_ready && !busy) ok = 1'b1;
    end
  endtask

  typedef struct {
    logic [1:0]  idx;
    logic        load;
    logic [15:0] a0, a1, b1;
    int          aw_d, w_d, tl, ek;
    logic [31:0] e0, e1, e2;
  } vec_t;

  vec_t vt[4];
  logic [35:0] ew[NW];

  initial begin
    int fk, base, dbase, dn;
    logic ok, got1, fin, found;

    vt[0] = '{2'd2, 1'b1, 16'h1000, 16'h0800, 16'hC000, 0, 3, 10, 11, 32'h0000_1000, 32'h0000_0800, 32'hFFFF_C000};
    vt[1] = '{2'd1, 1'b1, 16'h8000, 16'h7FFF, 16'hFFFF, 3, 0, 4,  5,  32'hFFFF_8000, 32'h0000_7FFF, 32'hFFFF_FFFF};
    vt[2] = '{2'd3, 1'b1, 16'h0001, 16'hF000, 16'h1234, 1, 1, 0,  17, 32'h0000_0001, 32'hFFFF_F000, 32'h0000_1234};
    vt[3] = '{2'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1,  2,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

    aresetn = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0; cfg_wdata = '0;
    req_valid = 1'b0; req_idx = '0; err_clr = 1'b0; set_mon(1'b0);
    aw_dly = 0; w_dly = 0; err_en = 1'b0; err_addr = 4'h8;
    repeat (3) @(negedge aclk);
    chk("rst_awvalid", m_axi.awvalid, 0);
    chk("rst_wvalid", m_axi.wvalid, 0);
    chk("rst_bready", m_axi.bready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_active", active_idx, 0);
    chk("rst_awaddr", m_axi.awaddr, 0);
    chk("rst_wdata", m_axi.wdata, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("wstrb", m_axi.wstrb, 4'hF);
    aresetn = 1'b1;

    for (int i = 0; i < 4; i++) begin
      aw_dly = vt[i].aw_d; w_dly = vt[i].w_d;
      if (vt[i].load) begin
        cfg_write(vt[i].idx, 2'd0, vt[i].a0);
        cfg_write(vt[i].idx, 2'd1, vt[i].a1);
        cfg_write(vt[i].idx, 2'd2, vt[i].b1);
        cfg_write(vt[i].idx, 2'd3, 16'hDEAD);
      end
      ew[0] = {4'h0, 32'h0};
      ew[1] = {4'h4, vt[i].e0};
      ew[2] = {4'h8, vt[i].e1};
      ew[3] = {4'hC, vt[i].e2};
`ifdef IIR_SEQ_CLEAR_EN
      ew[4] = {4'h0, 32'h2};
`endif
      ew[NW-1] = {4'h0, 32'h1};
      base = log_q.size(); dbase = done_cnt;
      run_req(vt[i].idx, vt[i].tl, fk);
      chk($sformatf("v%0d_first_aw_cycle", i), fk, vt[i].ek);
      wait_idle(ok);
      chk($sformatf("v%0d_finished", i), ok, 1);
      chk($sformatf("v%0d_nwrites", i), log_q.size() - base, NW);
      for (int j = 0; j < NW; j++) chk($sformatf("v%0d_wr%0d", i, j), ent(base + j), ew[j]);
      chk($sformatf("v%0d_done_pulses", i), done_cnt - dbase, 1);
      chk($sformatf("v%0d_active_idx", i), active_idx, vt[i].idx);
    end

    // Error response on the a1 write: sequence still ends with resume, err sticky until cleared.
    aw_dly = 0; w_dly = 0; err_en = 1'b1; err_addr = 4'h8;
    base = log_q.size();
    run_req(2'd2, 1, fk);
    wait_idle(ok);
    err_en = 1'b0;
    chk("err_finished", ok, 1);
    chk("err_set", err, 1);
    chk("err_nwrites", log_q.size() - base, NW);
    chk("err_b1_issued", ent(base + 3), {4'hC, 32'hFFFF_C000});
    chk("err_last_resume", ent(base + NW - 1), {4'h0, 32'h1});
    @(negedge aclk); err_clr = 1'b1;
    @(negedge aclk); err_clr = 1'b0;
    chk("err_cleared", err, 0);

    // Request held through busy; cfg write to preset 0 lands mid-sequence.
    base = log_q.size(); got1 = 1'b0; fin = 1'b0; dn = 0;
    @(negedge aclk); req_valid = 1'b1; req_idx = 2'd3;
    for (int n = 1; n < 400 && !fin; n++) begin
      @(negedge aclk);
      if (n == 2) begin
        req_idx = 2'd0; cfg_we = 1'b1; cfg_idx = 2'd0; cfg_sel = 2'd0; cfg_wdata = 16'h0055;
      end else cfg_we = 1'b0;
      if (n == 3) begin
        chk("hold_req_ready", req_ready, 0);
        chk("hold_busy", busy, 1);
      end
      set_mon(n == 5);
      if (done && !got1) begin
        got1 = 1'b1; dn = n;
        chk("hold_active_first", active_idx, 3);
      end
      if (got1 && n == dn + 1) chk("hold_req_ready_idle", req_ready, 1);
      if (got1 && n == dn + 2) begin
        req_valid = 1'b0;
        chk("hold_second_taken", busy, 1);
      end
      if (got1 && n > dn + 2 && !busy && req_ready) fin = 1'b1;
    end
    req_valid = 1'b0; set_mon(1'b0);
    chk("hold_finished", fin, 1);
    chk("hold_nwrites", log_q.size() - base, 2 * NW);
    chk("hold_first_a0", ent(base + 1), {4'h4, 32'h0000_0001});
    chk("hold_first_a1", ent(base + 2), {4'h8, 32'hFFFF_F000});
    chk("hold_first_b1", ent(base + 3), {4'hC, 32'h0000_1234});
    chk("hold_second_a0", ent(base + NW + 1), {4'h4, 32'h0000_0055});
    chk("hold_second_a1", ent(base + NW + 2), {4'h8, 32'h0});
    chk("hold_active_second", active_idx, 0);

    // Reset while the a1 write is still waiting for awready.
    aw_dly = 4; w_dly = 4; found = 1'b0;
    @(negedge aclk); req_valid = 1'b1; req_idx = 2'd2;
    for (int n = 1; n < 150 && !found; n++) begin
      @(negedge aclk);
      req_valid = 1'b0;
      set_mon(n == 1);
      if (m_axi.awvalid && m_axi.awaddr == 4'h8) found = 1'b1;
    end
    set_mon(1'b0);
    chk("rst_mid_reached_a1", found, 1);
    aresetn = 1'b0;
    @(negedge aclk);
    chk("rst_mid_awvalid", m_axi.awvalid, 0);
    chk("rst_mid_wvalid", m_axi.wvalid, 0);
    chk("rst_mid_bready", m_axi.bready, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_req_ready", req_ready, 1);
    chk("rst_mid_awaddr", m_axi.awaddr, 0);
    aresetn = 1'b1;
    aw_dly = 0; w_dly = 0;
    base = log_q.size();
    run_req(2'd2, 1, fk);
    wait_idle(ok);
    chk("post_rst_finished", ok, 1);
    chk("post_rst_table_cleared", ent(base + 1), {4'h4, 32'h0});
    chk("bready_before_handshakes", bready_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
